// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared encodings and defaults for the multiply/divide
//                sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Operation encodings carried on the op bus
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Default busy lengths and counter width
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W_DEF       = 4;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the multi-cycle unit (MULT/MULTU/DIV/DIVU)
    function automatic logic is_md_op(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl_if
//  Description : Request/result bundle between the execute stage and the
//                multiply/divide controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        xstall;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues requests, observes status and HI/LO
    modport master (
        output start, op, a, b, md_use,
        input  busy, xstall, hi, lo
    );

    // Controller side
    modport slave (
        input  start, op, a, b, md_use,
        output busy, xstall, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_ctrl_calc.sv
`default_nettype none
// ============================================================================
//  Module      : md_calc
//  Description : Combinational multiply/divide datapath. Produces the HI/LO
//                values an op would commit and flags division by zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_calc
    import md_pkg::*;
(
    input  wire logic [2:0]  i_op,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [31:0] o_hi,
    output logic      [31:0] o_lo,
    output logic             o_div_by_zero
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;

    assign w_sa     = $signed(i_a);
    assign w_sb     = $signed(i_b);
    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Select result per op; divide paths guard zero and the one signed overflow case
    always_comb begin
        o_hi          = '0;
        o_lo          = '0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV: begin
                if (i_b == 32'd0) begin
                    o_div_by_zero = 1'b1;
                end else if (i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF) begin
                    o_lo = 32'h8000_0000;
                    o_hi = 32'd0;
                end else begin
                    o_lo = w_sa / w_sb;
                    o_hi = w_sa % w_sb;
                end
            end
            MD_DIVU: begin
                if (i_b == 32'd0) begin
                    o_div_by_zero = 1'b1;
                end else begin
                    o_lo = i_a / i_b;
                    o_hi = i_a % i_b;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl
//  Description : Sequencing controller for the shared multiply/divide unit.
//                Holds the unit busy for a fixed cycle count, commits HI/LO
//                on completion and raises xstall for HI/LO users in decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int CNT_W       = MD_CNT_W_DEF
)
(
    input  wire logic  clk,
    input  wire logic  reset,
    md_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       res_hi_q, res_hi_d;
    logic [31:0]       res_lo_q, res_lo_d;
    logic              res_dz_q, res_dz_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic [31:0]       w_calc_hi;
    logic [31:0]       w_calc_lo;
    logic              w_calc_dz;
    logic              w_busy;

    md_calc u_calc (
        .i_op          (bus.op),
        .i_a           (bus.a),
        .i_b           (bus.b),
        .o_hi          (w_calc_hi),
        .o_lo          (w_calc_lo),
        .o_div_by_zero (w_calc_dz)
    );

    // Next-state: accept requests in IDLE, count down and commit in RUN
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_dz_d = res_dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MD_MULT, MD_MULTU: begin
                            res_hi_d = w_calc_hi;
                            res_lo_d = w_calc_lo;
                            res_dz_d = 1'b0;
                            cnt_d    = c_mult_cnt;
                            state_d  = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            res_hi_d = w_calc_hi;
                            res_lo_d = w_calc_lo;
                            res_dz_d = w_calc_dz;
                            cnt_d    = c_div_cnt;
                            state_d  = RUN;
                        end
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving here are dropped; the stall should prevent them
                cnt_d = cnt_q - c_last_cnt;
                if (cnt_q == c_last_cnt) begin
                    if (!res_dz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, result latches and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_dz_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_dz_q <= res_dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign w_busy     = (state_q == RUN);
    assign bus.busy   = w_busy;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    // Stall a HI/LO consumer while the unit runs or is being started this cycle
    assign bus.xstall = bus.md_use && (w_busy || (bus.start && is_md_op(bus.op)));

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Self-checking bench for md_ctrl with a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;
    import md_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    res_t sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_ctrl_if bus();

    md_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
    endtask

    // Count remaining busy cycles, then pop the scoreboard and compare HI/LO
    task automatic finish_md(input string name, input int n0, input int ecyc);
        int   n;
        res_t exp;
        n = n0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++;
        if (n !== ecyc) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, ecyc);
        end
        exp = sb_q.pop_front();
        total++;
        if (bus.hi !== exp.hi || bus.lo !== exp.lo) begin
            bad++;
            $display("FAIL %s hilo got=%h_%h exp=%h_%h", name, bus.hi, bus.lo, exp.hi, exp.lo);
        end
        m_hi = exp.hi;
        m_lo = exp.lo;
    endtask

    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc);
        sb_q.push_back('{hi: ehi, lo: elo});
        issue(op, a, b);
        finish_md(name, 0, ecyc);
    endtask

    task automatic move_to(input string name, input logic [2:0] op, input logic [31:0] a);
        issue(op, a, 32'd0);
        if (op == MD_MTHI) m_hi = a;
        else               m_lo = a;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            bad++;
            $display("FAIL %s busy=%b hilo got=%h_%h exp=0_%h_%h", name, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        bus.md_use = 1'b1;
        #12;
        total++;
        if (bus.busy !== 1'b0 || bus.xstall !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state busy=%b xstall=%b hi=%h lo=%h exp=0/0/0/0", bus.busy, bus.xstall, bus.hi, bus.lo);
        end
        bus.md_use = 1'b0;
        bus.start  = 1'b1;
        bus.op     = MD_MULT;
        bus.a      = 32'd3;
        bus.b      = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_start_ignored busy=%b hi=%h lo=%h exp=0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        run_md("mult_signed", MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_md("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    endtask

    task automatic test_div();
        run_md("div_signed", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_md("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run_md("div_overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    endtask

    task automatic test_div_zero();
        move_to("mthi", MD_MTHI, 32'h1234);
        move_to("mtlo", MD_MTLO, 32'h5678);
        run_md("div_by_zero", MD_DIV, 32'd99, 32'd0, 32'h1234, 32'h5678, 10);
    endtask

    task automatic test_xstall();
        int errs;
        bus.md_use = 1'b1;
        bus.start  = 1'b1;
        bus.op     = MD_MULT;
        bus.a      = 32'd6;
        bus.b      = 32'd7;
        sb_q.push_back('{hi: 32'd0, lo: 32'd42});
        #3;
        total++;
        if (bus.xstall !== 1'b1) begin
            bad++;
            $display("FAIL xstall_start_cycle got=%b exp=1", bus.xstall);
        end
        tick();
        bus.start = 1'b0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy !== 1'b1 || bus.xstall !== 1'b1) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL xstall_busy_cycles bad_cycles=%0d exp=0", errs);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.xstall !== 1'b0) begin
            bad++;
            $display("FAIL xstall_release busy=%b xstall=%b exp=0/0", bus.busy, bus.xstall);
        end
        finish_md("xstall_mult", 5, 5);
        // MTHI with md_use does not start the unit, so no stall
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.a     = 32'h0000_00AB;
        #3;
        total++;
        if (bus.xstall !== 1'b0) begin
            bad++;
            $display("FAIL xstall_mthi got=%b exp=0", bus.xstall);
        end
        tick();
        bus.start  = 1'b0;
        m_hi       = 32'h0000_00AB;
        bus.md_use = 1'b0;
        sb_q.push_back('{hi: 32'd0, lo: 32'd4});
        issue(MD_MULTU, 32'd2, 32'd2);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy !== 1'b1 || bus.xstall !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL xstall_no_use bad_cycles=%0d exp=0", errs);
        end
        finish_md("no_use_mult", 5, 5);
    endtask

    task automatic test_ignored();
        sb_q.push_back('{hi: 32'd1, lo: 32'd0});
        issue(MD_MULT, 32'h0001_0000, 32'h0001_0000);
        issue(MD_MTLO, 32'h0000_DEAD, 32'd0);
        issue(MD_MULT, 32'd1, 32'd1);
        finish_md("start_during_run", 2, 5);
        issue(3'd6, 32'h99, 32'h99);
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            bad++;
            $display("FAIL reserved_op6 busy=%b hilo got=%h_%h exp=0_%h_%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
        issue(3'd7, 32'h77, 32'h77);
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            bad++;
            $display("FAIL reserved_op7 busy=%b hilo got=%h_%h exp=0_%h_%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_run();
        int errs;
        move_to("mthi_pre_reset", MD_MTHI, 32'h0000_AAAA);
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_run busy=%b hi=%h lo=%h exp=0/0/0", bus.busy, bus.hi, bus.lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        errs  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_late_commit busy_cycles=%0d hi=%h lo=%h exp=0/0/0", errs, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        run_md("b2b_div", MD_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 10);
        run_md("b2b_mult", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.md_use = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_xstall();
        test_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencing controller for the multi-cycle multiply/divide resource shared by the pipeline.
- Accepts a start request with operands from the execute stage and holds the unit busy for a fixed number of cycles.
- Commits HI/LO when the operation completes.
- Drives the extra-stall (xstall) condition into the pipeline registers while a HI/LO-dependent instruction sits in decode.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1, < 2**CNT_W)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1, < 2**CNT_W)
CNT_W, 4, width of the busy countdown counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  execute-stage request; qualifies op/a/b for one cycle
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6..7 reserved (no effect)
a  input  32  operand rs
b  input  32  operand rt
md_use  input  1  instruction in decode reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult*/div*)
busy  output  1  unit running a MULT/DIV
xstall  output  1  pipeline stall request = md_use && (busy || start_md), where start_md = start && op<=3
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0, any time, independent of clk):
  - state=IDLE, counter=0, hi=0, lo=0, busy=0.
  - xstall then evaluates to 0 because busy=0 during reset; start is ignored while reset is asserted.
- States: IDLE, RUN.
- busy = (state==RUN), registered.
- IDLE, start && op in {0,1}:
  - Compute 64-bit product at the start edge; hold it in result_hi/result_lo.
  - Load counter=MULT_CYCLES; go RUN.
  - MULT: signed*signed. MULTU: unsigned*unsigned.
- IDLE, start && op in {2,3}:
  - Latch quotient/remainder; counter=DIV_CYCLES; go RUN.
  - DIV: signed, quotient truncates toward zero, remainder takes sign of dividend.
  - DIVU: unsigned.
  - Quotient -> LO, remainder -> HI.
- Division by zero (b==0): still busy DIV_CYCLES cycles; HI/LO left unchanged on completion.
- Overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- IDLE, start && op==4: hi<=a at that edge; op==5: lo<=a. No busy.
- IDLE, start && op in {6,7}: ignored.
- RUN:
  - counter decrements each edge.
  - On the edge where counter==1: commit hi/lo (except div-by-zero); go IDLE.
  - busy is therefore high for exactly N cycles after the start edge; new hi/lo are visible in the first cycle busy==0.
- start while RUN: ignored entirely, including MTHI/MTLO. The pipeline guarantees this cannot occur because xstall holds the requester; the bench must check it is ignored anyway.
- xstall is combinational from registered busy and the start/op/md_use inputs; no extra latency.
- Reset asserted mid-RUN: operation abandoned; hi/lo return to 0 and no commit occurs.

Decomposition:
- Shared package md_pkg: op encodings (MD_MULT..MD_MTLO), state encoding (IDLE, RUN), default cycle-count constants.
- One sub-module, md_calc: purely combinational; given op/a/b produces 32-bit hi/lo results and a div_by_zero flag.
- md_ctrl holds the FSM, counter, result latches and HI/LO registers.

Test Plan:
- Reset low mid-RUN of a DIV (cycle 4 of 10) -> busy=0, hi=lo=0 immediately (asynchronous); after release, busy stays 0 and no late commit.
- MULT a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIV with b=0 after MTHI a=0x1234, MTLO a=0x5678 -> busy 10 cycles; hi=0x1234 and lo=0x5678 unchanged.
- MULT start with md_use=1 in the same cycle -> xstall=1 that cycle and all 5 busy cycles; 0 in the cycle busy falls. md_use=0 during busy -> xstall=0.
- start with op=MTLO during RUN -> lo unchanged; start with op=6 in IDLE -> no state, hi or lo change.
